comparator_eq_serial_ctrl: RTL and testbench

//  Sequencer that computes a == b for N-bit operands using a single shared
//  8-bit equality slice (comparator_eq_8bit), one byte per cycle, LSB first.

---
 rtl/comparator_eq_serial_ctrl_pkg.sv | 12 +
 rtl/comparator_eq_8bit.sv | 12 +
 rtl/comparator_eq_serial_ctrl.sv | 106 ++++++++++
 tb/tb_comparator_eq_serial_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/comparator_eq_serial_ctrl_pkg.sv
// Shared constants and FSM encoding for the byte-serial equality comparator.
package comparator_eq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/comparator_eq_8bit.sv
// Single byte equality slice, time-shared by the serial controller.
module comparator_eq_8bit
  import comparator_eq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  output logic               o_eq
);

  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/comparator_eq_serial_ctrl.sv
// Byte-serial a==b sequencer: one shared 8-bit slice, LSB byte first,
// valid/ready on request and result sides, optional early exit on mismatch.
module comparator_eq_serial_ctrl
  import comparator_eq_pkg::*;
#(
  parameter int N          = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 out,
  output logic [$clog2(N/8):0] o_cycles
);

  localparam int                SLICES = N / SLICE_W;
  localparam int                IDX_W  = $clog2(SLICES) + 1;
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(SLICES - 1);
  localparam logic [IDX_W-1:0]  FULL   = IDX_W'(SLICES);

  cmp_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic               r_match;
  logic               r_out;
  logic [IDX_W-1:0]   r_cycles;

  logic [SLICE_W-1:0] w_a_byte;
  logic [SLICE_W-1:0] w_b_byte;
  logic               w_byte_eq;

  // Explicit decode keeps the select inside the operand range for any idx value.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_byte = r_a[i*SLICE_W +: SLICE_W];
        w_b_byte = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  comparator_eq_8bit u_slice (
    .i_a  (w_a_byte),
    .i_b  (w_b_byte),
    .o_eq (w_byte_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_match  <= 1'b1;
      r_out    <= 1'b0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_match <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_match <= r_match & w_byte_eq;
          // idx returns to 0 on exit so its registered value stays within range.
          if (EARLY_EXIT && !w_byte_eq) begin
            r_out    <= 1'b0;
            r_cycles <= r_idx + 1'b1;
            r_idx    <= '0;
            r_state  <= S_DONE;
          end else if (r_idx == LAST) begin
            r_out    <= r_match & w_byte_eq;
            r_cycles <= FULL;
            r_idx    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (o_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign out      = r_out;
  assign o_cycles = r_cycles;

endmodule

// File: tb/tb_comparator_eq_serial_ctrl.sv
// Directed + random bench: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance in lockstep.
module tb_comparator_eq_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        o_ready1 = 1'b0;
  logic        o_ready0 = 1'b0;
  logic        i_ready1, i_ready0;
  logic        o_valid1, o_valid0;
  logic        out1, out0;
  logic [2:0]  o_cycles1, o_cycles0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comparator_eq_serial_ctrl #(.N(32), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1),
    .a(a), .b(b), .o_valid(o_valid1), .o_ready(o_ready1),
    .out(out1), .o_cycles(o_cycles1)
  );

  comparator_eq_serial_ctrl #(.N(32), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready0),
    .a(a), .b(b), .o_valid(o_valid0), .o_ready(o_ready0),
    .out(out0), .o_cycles(o_cycles0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through both instances; hold = cycles of o_ready=0 after both valid.
  task automatic do_req(input logic [31:0] ta, input logic [31:0] tb_, input int hold, input bit rnd);
    int fm, lat1, lat0;
    logic [31:0] exp_c1, exp_eq;
    fm = 4;
    for (int i = 3; i >= 0; i--) if (ta[8*i +: 8] != tb_[8*i +: 8]) fm = i;
    exp_c1 = (fm < 4) ? 32'(fm + 1) : 32'd4;
    exp_eq = (ta == tb_) ? 32'd1 : 32'd0;

    chk("idle_ready_ee", 32'(i_ready1), 32'd1);
    chk("idle_ready_full", 32'(i_ready0), 32'd1);
    a = ta; b = tb_; i_valid = 1'b1; o_ready1 = 1'b0; o_ready0 = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0; a = $urandom; b = $urandom;
    lat1 = 0; lat0 = 0;
    for (int cyc = 1; cyc <= 20 && (lat1 == 0 || lat0 == 0); cyc++) begin
      if (rnd) begin
        i_valid = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom;
        if (lat1 == 0) o_ready1 = 1'($urandom_range(0, 1));
        if (lat0 == 0) o_ready0 = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (lat1 == 0 && o_valid1) begin lat1 = cyc; o_ready1 = 1'b0; end
      if (lat0 == 0 && o_valid0) begin lat0 = cyc; o_ready0 = 1'b0; end
    end
    i_valid = 1'b0;
    chk("latency_ee", 32'(lat1), exp_c1);
    chk("latency_full", 32'(lat0), 32'd4);

    for (int h = 0; h < hold; h++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_valid_ee", 32'(o_valid1), 32'd1);
      chk("hold_valid_full", 32'(o_valid0), 32'd1);
      chk("hold_iready_ee", 32'(i_ready1), 32'd0);
      chk("hold_out_ee", 32'(out1), exp_eq);
      chk("hold_cyc_ee", 32'(o_cycles1), exp_c1);
      chk("hold_out_full", 32'(out0), exp_eq);
    end

    chk("out_ee", 32'(out1), exp_eq);
    chk("cycles_ee", 32'(o_cycles1), exp_c1);
    chk("out_full", 32'(out0), exp_eq);
    chk("cycles_full", 32'(o_cycles0), 32'd4);

    o_ready1 = 1'b1; o_ready0 = 1'b1;
    if (rnd) i_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    o_ready1 = 1'b0; o_ready0 = 1'b0; i_valid = 1'b0;
    chk("release_valid_ee", 32'(o_valid1), 32'd0);
    chk("release_valid_full", 32'(o_valid0), 32'd0);
    chk("release_iready_ee", 32'(i_ready1), 32'd1);
    chk("release_iready_full", 32'(i_ready0), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_iready_ee", 32'(i_ready1), 32'd1);
    chk("rst_ovalid_ee", 32'(o_valid1), 32'd0);
    chk("rst_out_ee", 32'(out1), 32'd0);
    chk("rst_cycles_ee", 32'(o_cycles1), 32'd0);
    chk("rst_iready_full", 32'(i_ready0), 32'd1);
    chk("rst_ovalid_full", 32'(o_valid0), 32'd0);

    // o_ready pulsed while idle must not disturb anything
    o_ready1 = 1'b1; o_ready0 = 1'b1;
    @(posedge clk); #1;
    o_ready1 = 1'b0; o_ready0 = 1'b0;
    chk("idle_oready_ovalid", 32'(o_valid1), 32'd0);

    do_req(32'hDEADBEEF, 32'hDEADBEEF, 0, 1'b0);
    do_req(32'h12345678, 32'h12345679, 0, 1'b0);
    do_req(32'h80000000, 32'h00000000, 0, 1'b0);
    do_req(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    do_req(32'h11223344, 32'h11FF3344, 0, 1'b0);
    do_req(32'hCAFEF00D, 32'hCAFE000D, 5, 1'b0);
    do_req(32'h00000000, 32'h00000001, 0, 1'b0);

    // reset two clocks after accept aborts the compare
    a = 32'hDEADBEEF; b = 32'hDEADBEEF; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_iready_ee", 32'(i_ready1), 32'd1);
    chk("midrst_ovalid_ee", 32'(o_valid1), 32'd0);
    chk("midrst_out_ee", 32'(out1), 32'd0);
    chk("midrst_cycles_ee", 32'(o_cycles1), 32'd0);
    chk("midrst_iready_full", 32'(i_ready0), 32'd1);
    chk("midrst_ovalid_full", 32'(o_valid0), 32'd0);
    do_req(32'h00000000, 32'h00000000, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    rb = ra;
        2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: ;
      endcase
      do_req(ra, rb, $urandom_range(0, 2), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
